// File: rtl/cskipa_acc_stage_pkg.sv
// Shared definitions for the carry-skip adder result stage:
// default widths, output FIFO depth and the FIFO entry layout.
package cskipa_acc_stage_pkg;

    localparam int DEF_WIDTH  = 25;
    localparam int DEF_CNT_W  = 8;
    localparam int FIFO_DEPTH = 2;

    // One result as it travels through the output FIFO (MSB first: result, carry, count).
    typedef struct packed {
        logic [DEF_WIDTH-1:0] result;
        logic                 carry;
        logic [DEF_CNT_W-1:0] count;
    } res_entry_t;

    localparam int DEF_ENTRY_W = $bits(res_entry_t);

endpackage

// File: rtl/cskipa_res_fifo.sv
// Two-entry result FIFO. Occupancy, pointers and storage are all registered,
// so full/valid/head never depend combinationally on push/pop.
module cskipa_res_fifo
    import cskipa_acc_stage_pkg::*;
#(
    parameter int ENTRY_W = DEF_ENTRY_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_push,
    input  logic [ENTRY_W-1:0] i_data,
    input  logic               i_pop,
    output logic               o_full,
    output logic               o_valid,
    output logic [ENTRY_W-1:0] o_data
);

    localparam logic [1:0] FULL_OCC = 2'(FIFO_DEPTH);

    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0] mem_d [FIFO_DEPTH];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         occ_q, occ_d;
    logic               do_push_s, do_pop_s;

    assign o_full  = (occ_q == FULL_OCC);
    assign o_valid = (occ_q != 2'd0);
    assign o_data  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        do_push_s = i_push && (occ_q != FULL_OCC);
        do_pop_s  = i_pop && (occ_q != 2'd0);
        if (do_push_s) begin
            mem_d[wr_ptr_q] = i_data;
            wr_ptr_d        = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // FIFO state registers; reset empties the FIFO and zeroes the head.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

endmodule

// File: rtl/cskipa_acc_stage.sv
// Registered result stage behind the 25-bit carry-skip adder.
// Pass beats become standalone results; accumulate beats build a running
// total in o_acc (fed back to the adder) until i_last closes the burst.
// Optional macro CSKIPA_ACC_SAT_EN: saturate the accumulator to all-ones on
// overflow instead of wrapping.
module cskipa_acc_stage
    import cskipa_acc_stage_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_sum,
    input  logic             i_cout,
    input  logic             i_acc_mode,
    input  logic             i_last,
    output logic [WIDTH-1:0] o_acc,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic [CNT_W-1:0] o_count
);

    localparam int               ENTRY_W = WIDTH + 1 + CNT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               fifo_full_s;
    logic               burst_open_s;
    logic               switch_s;
    logic               close_s;
    logic               accept_s;
    logic               push_s;
    logic [ENTRY_W-1:0] push_data_s;
    logic [ENTRY_W-1:0] head_s;
    logic [CNT_W-1:0]   cnt_inc_s;
    logic               ovf_any_s;
    logic [WIDTH-1:0]   acc_val_s;

    // Handshake and helper terms. A pass beat behind an open burst is held
    // off (ready low) while the burst itself is flushed into the FIFO.
    always_comb begin
        burst_open_s = (cnt_q != '0);
        switch_s     = burst_open_s && !i_acc_mode;
        o_ready      = !fifo_full_s && !switch_s;
        close_s      = i_valid && switch_s && !fifo_full_s;
        accept_s     = i_valid && o_ready;
        cnt_inc_s    = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
        ovf_any_s    = ovf_q | i_cout;
`ifdef CSKIPA_ACC_SAT_EN
        acc_val_s    = ovf_any_s ? {WIDTH{1'b1}} : i_sum;
`else
        acc_val_s    = i_sum;
`endif
    end

    // Burst control: update the accumulator and decide what gets pushed.
    always_comb begin
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        push_s      = 1'b0;
        push_data_s = '0;
        if (close_s) begin
            push_s      = 1'b1;
            push_data_s = {acc_q, ovf_q, cnt_q};
            acc_d       = '0;
            ovf_d       = 1'b0;
            cnt_d       = '0;
        end else if (accept_s) begin
            if (i_acc_mode) begin
                if (i_last) begin
                    push_s      = 1'b1;
                    push_data_s = {acc_val_s, ovf_any_s, cnt_inc_s};
                    acc_d       = '0;
                    ovf_d       = 1'b0;
                    cnt_d       = '0;
                end else begin
                    acc_d = acc_val_s;
                    ovf_d = ovf_any_s;
                    cnt_d = cnt_inc_s;
                end
            end else begin
                push_s      = 1'b1;
                push_data_s = {i_sum, i_cout, CNT_ONE};
            end
        end else begin
            push_s = 1'b0;
        end
    end

    // Accumulator and burst state registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
        end
    end

    cskipa_res_fifo #(
        .ENTRY_W (ENTRY_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push_s),
        .i_data  (push_data_s),
        .i_pop   (i_ready),
        .o_full  (fifo_full_s),
        .o_valid (o_valid),
        .o_data  (head_s)
    );

    assign o_acc                         = acc_q;
    assign {o_result, o_carry, o_count}  = head_s;

endmodule

// File: doc/cskipa_acc_stage.md
Name: cskipa_acc_stage

Overview:
- Registered result stage directly downstream of the 25-bit carry-skip adder; consumes its combinational sum/cout.
- Pass mode: each accepted beat is a standalone result.
- Accumulate mode: the stage holds a running total in o_acc. The datapath wires o_acc back into the adder's second operand, so i_sum = o_acc + term. A burst closes on i_last.
- Results leave through a 2-entry output FIFO with a valid/ready handshake.

Parameters:
- WIDTH, 25, adder/result width in bits.
- CNT_W, 8, width of the per-result beat counter.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  upstream beat valid (adder output settled).
- o_ready  output  1  stage can accept a beat.
- i_sum  input  WIDTH  adder sum.
- i_cout  input  1  adder carry-out.
- i_acc_mode  input  1  1 = accumulate beat, 0 = pass beat.
- i_last  input  1  closes the accumulate burst; ignored in pass mode.
- o_acc  output  WIDTH  running accumulator, fed back to adder operand 2.
- o_valid  output  1  output FIFO non-empty.
- i_ready  input  1  downstream accepts the head entry.
- o_result  output  WIDTH  head entry result.
- o_carry  output  1  head entry carry/overflow flag.
- o_count  output  CNT_W  head entry beat count.

Behaviour:
- Reset (async, i_rst=1): all outputs reset as follows.
  - o_acc=0, o_valid=0, o_result=0, o_carry=0, o_count=0, o_ready=1.
  - FIFO emptied; burst state cleared (ovf_sticky=0, beat_cnt=0).
  - Reset mid-burst discards the partial burst and all FIFO contents.
- Handshakes:
  - Accept = i_valid & o_ready. Pop = o_valid & i_ready.
  - o_ready = FIFO occupancy < 2. It is derived from registered occupancy only, with no combinational path from i_ready.
- Pass beat (i_acc_mode=0, no burst open): push {i_sum, i_cout, count=1}. o_acc is unchanged.
- Accumulate beat, i_last=0:
  - o_acc <= i_sum; ovf_sticky <= ovf_sticky | i_cout; beat_cnt <= beat_cnt+1.
  - beat_cnt saturates at 2^CNT_W-1. No push.
- Accumulate beat, i_last=1:
  - Push {i_sum, ovf_sticky | i_cout, beat_cnt+1 (saturating)}.
  - Then o_acc <= 0, ovf_sticky <= 0, beat_cnt <= 0.
- Pass beat while a burst is open (beat_cnt>0):
  - The open burst is closed first: push {o_acc, ovf_sticky, beat_cnt}.
  - The pass beat itself is not accepted that cycle (o_ready forced 0 for this case). It is accepted on a later cycle once the burst is clear.
- Latency: one cycle from accept to o_valid when the FIFO is empty. No combinational path from i_* to o_result.
- FIFO ordering:
  - Strict ordering; the head is stable while o_valid & !i_ready.
  - Push and pop in the same cycle at occupancy 1: occupancy stays 1 and the head advances.
  - At occupancy 2, no push is possible.
- o_acc is a plain register. Upstream reads it combinationally to form the next adder operand.

Optional Feature:
- Macro: CSKIPA_ACC_SAT_EN.
- Defined: in accumulate mode, any i_cout=1 or an already-set ovf_sticky forces o_acc <= all-ones (2^WIDTH-1). The saturated value is held until burst close, and the closing result is all-ones with o_carry=1. Pass beats are unaffected.
- Undefined: the accumulator wraps modulo 2^WIDTH and overflow is reported only via o_carry.

Decomposition:
- Shared package holds:
  - the FIFO entry typedef {result, carry, count};
  - the FIFO depth constant 2;
  - the default WIDTH/CNT_W constants.
- One sub-module is natural: cskipa_res_fifo (2-entry, registered-occupancy FIFO), parameterised by entry width.
- Burst/accumulator control stays in the top.

Test Plan:
- Pass mode: 3 beats i_sum=0x0000005, 0x1FFFFFF (cout=1), 0x0ABCDEF with i_ready=1 -> results emitted in order with carry 0/1/0, o_count=1 each, first o_valid one cycle after accept.
- Accumulate: terms 10, 20, 30 with i_last on 30 and the adder model closed around o_acc -> o_acc sequence 10, 30; result 60, o_carry=0, o_count=3; o_acc=0 afterwards.
- Accumulate overflow: o_acc=0x1FFFFF0 plus term 0x20 (cout=1), then term 1 with last -> wrap build: result 0x0000011, o_carry=1; with CSKIPA_ACC_SAT_EN: result 0x1FFFFFF, o_carry=1.
- Backpressure: i_ready=0 while 3 pass beats are offered -> o_ready drops after 2 accepts; the head stays stable; releasing i_ready drains in order, and the third beat is accepted the cycle after the first pop.
- Mode switch: 2 accumulate beats (5, 7), then a pass beat 0x100 -> burst result 12, count 2 pushed first; the pass beat is accepted on a later cycle, result 0x100, count 1.
- Async reset asserted mid-burst with 2 FIFO entries -> all outputs 0 immediately and o_ready=1; after release, a fresh pass beat emits with o_count=1.
